// File: rtl/seq_divider_16bit_if.sv
// Request/result bundle for the iterative divider: operands and mode in,
// quotient/remainder/flags out, valid/ready on both sides.
// Ports: master = requester/consumer side, slave = divider side.
interface seq_divider_16bit_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             signed_op;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             out_valid;
   logic             out_ready;
   logic             div_by_zero;
   logic             busy;
   logic             power_saved;

   modport master (
      output start, dividend, divisor, signed_op, out_ready,
      input  in_ready, quotient, remainder, out_valid, div_by_zero, busy, power_saved
   );

   modport slave (
      input  start, dividend, divisor, signed_op, out_ready,
      output in_ready, quotient, remainder, out_valid, div_by_zero, busy, power_saved
   );
endinterface

// File: rtl/seq_divider_16bit.sv
// Restoring shift-subtract divider, signed/unsigned, one quotient bit per cycle.
// Latency: WIDTH+2 edges after accept; zero divisor/dividend exit straight to DONE.
// Backpressure: result held in DONE until out_ready; start ignored while busy.
// Ports: gated_clk/rst_n (async active-low); bus = seq_divider_16bit_if slave
//   (start/in_ready request side, out_valid/out_ready result side, flags).
module seq_divider_16bit #(
   parameter int WIDTH = 16
) (
   input logic                gated_clk,
   input logic                rst_n,
   seq_divider_16bit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t           state_q, state_d;
   // dvd_q holds the raw dividend, then its magnitude, and finally the
   // quotient magnitude as quotient bits shift in from the bottom.
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sop_q, sop_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic             dbz_q, dbz_d;
   logic             psv_q, psv_d;

   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   rem_sub;
   logic             q_bit;

   always_ff @(posedge gated_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dvd_q     <= '0;
         dsr_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         sop_q     <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         quo_q     <= '0;
         rmd_q     <= '0;
         dbz_q     <= 1'b0;
         psv_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dvd_q     <= dvd_d;
         dsr_q     <= dsr_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         sop_q     <= sop_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         quo_q     <= quo_d;
         rmd_q     <= rmd_d;
         dbz_q     <= dbz_d;
         psv_q     <= psv_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dvd_d     = dvd_q;
      dsr_d     = dsr_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      sop_d     = sop_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      quo_d     = quo_q;
      rmd_d     = rmd_q;
      dbz_d     = dbz_q;
      psv_d     = psv_q;

      // One restoring step: bring in the next dividend bit, trial-subtract.
      rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
      rem_sub   = rem_shift - {1'b0, dsr_q};
      q_bit     = (rem_shift >= {1'b0, dsr_q});

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               dvd_d = bus.dividend;
               dsr_d = bus.divisor;
               sop_d = bus.signed_op;
               if (bus.divisor == '0) begin
                  quo_d   = '1;
                  rmd_d   = bus.dividend;
                  dbz_d   = 1'b1;
                  psv_d   = 1'b1;
                  state_d = DONE;
               end else if (bus.dividend == '0) begin
                  quo_d   = '0;
                  rmd_d   = '0;
                  dbz_d   = 1'b0;
                  psv_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = PREP;
               end
            end
         end
         PREP: begin
            neg_quo_d = sop_q & (dvd_q[WIDTH-1] ^ dsr_q[WIDTH-1]);
            neg_rem_d = sop_q & dvd_q[WIDTH-1];
            // abs(0x8000) stays 0x8000, which is the correct unsigned magnitude.
            if (sop_q && dvd_q[WIDTH-1]) dvd_d = -dvd_q;
            if (sop_q && dsr_q[WIDTH-1]) dsr_d = -dsr_q;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = ITER;
         end
         ITER: begin
            rem_d = q_bit ? rem_sub : rem_shift;
            dvd_d = {dvd_q[WIDTH-2:0], q_bit};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = FIX;
         end
         FIX: begin
            quo_d   = neg_quo_q ? (-dvd_q) : dvd_q;
            rmd_d   = neg_rem_q ? (-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
            dbz_d   = 1'b0;
            psv_d   = 1'b0;
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs come from the state register only.
   assign bus.in_ready    = (state_q == IDLE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.out_valid   = (state_q == DONE);
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rmd_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.power_saved = psv_q;
endmodule

// File: tb/tb_seq_divider_16bit.sv
// Self-checking bench for seq_divider_16bit: directed corner cases, backpressure,
// mid-operation reset, then randomized operands against an arithmetic model.
module tb_seq_divider_16bit;
   logic gated_clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   seq_divider_16bit_if #(.WIDTH(16)) bus ();

   seq_divider_16bit #(.WIDTH(16)) dut (
      .gated_clk (gated_clk),
      .rst_n     (rst_n),
      .bus       (bus.slave)
   );

   initial gated_clk = 1'b0;
   always #5 gated_clk = ~gated_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division semantics (truncate toward zero,
   // remainder takes the dividend's sign), plus the zero-operand rules.
   task automatic ref_div(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [15:0] q, output logic [15:0] r,
                          output logic dbz, output logic psv);
      int ia, ib, iq, ir;
      if (b == 16'h0) begin
         q = 16'hFFFF; r = a; dbz = 1'b1; psv = 1'b1;
      end else if (a == 16'h0) begin
         q = 16'h0; r = 16'h0; dbz = 1'b0; psv = 1'b1;
      end else begin
         if (s) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
         end else begin
            ia = int'({16'h0, a});
            ib = int'({16'h0, b});
         end
         iq = ia / ib;
         ir = ia % ib;
         q = iq[15:0]; r = ir[15:0]; dbz = 1'b0; psv = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge gated_clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready"}, bus.in_ready, 1);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_quotient"}, bus.quotient, 0);
      check({tag, "_remainder"}, bus.remainder, 0);
      check({tag, "_dbz"}, bus.div_by_zero, 0);
      check({tag, "_psv"}, bus.power_saved, 0);
   endtask

   // Issue one request, check latency and result, hold off out_ready for
   // 'hold' cycles (pulsing a stray start each cycle), then retire it.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input int hold);
      int lat;
      logic [15:0] eq, er;
      logic edbz, epsv;
      ref_div(a, b, s, eq, er, edbz, epsv);
      lat = 0;
      while (!bus.in_ready && lat < 50) begin
         tick();
         lat++;
      end
      check({tag, "_idle"}, bus.in_ready, 1);
      bus.dividend  = a;
      bus.divisor   = b;
      bus.signed_op = s;
      bus.start     = 1'b1;
      tick();
      bus.start    = 1'b0;
      bus.dividend = 16'hDEAD;
      bus.divisor  = 16'hBEEF;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         check({tag, "_busy"}, bus.busy, 1);
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, (a == 16'h0 || b == 16'h0) ? 0 : 18);
      check({tag, "_quotient"}, bus.quotient, eq);
      check({tag, "_remainder"}, bus.remainder, er);
      check({tag, "_dbz"}, bus.div_by_zero, edbz);
      check({tag, "_psv"}, bus.power_saved, epsv);
      for (int i = 0; i < hold; i++) begin
         bus.start     = 1'b1;
         bus.dividend  = 16'($urandom);
         bus.divisor   = 16'($urandom);
         bus.signed_op = 1'($urandom);
         tick();
         check({tag, "_hold_valid"}, bus.out_valid, 1);
         check({tag, "_hold_in_ready"}, bus.in_ready, 0);
         check({tag, "_hold_q_r"}, {bus.quotient, bus.remainder}, {eq, er});
         check({tag, "_hold_flags"}, {bus.div_by_zero, bus.power_saved}, {edbz, epsv});
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_valid_drop"}, bus.out_valid, 0);
      check({tag, "_ready_back"}, bus.in_ready, 1);
      check({tag, "_after_q_r"}, {bus.quotient, bus.remainder}, {eq, er});
   endtask

   initial begin
      logic [15:0] ra, rb;
      int sel;
      n_vec         = 0;
      n_err         = 0;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.dividend  = 16'h0;
      bus.divisor   = 16'h0;
      bus.signed_op = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      check_reset_state("reset");
      rst_n = 1'b1;
      tick();

      // out_ready while idle must not disturb anything.
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("idle_out_ready", {bus.in_ready, bus.out_valid}, 2'b10);

      run_op("u1000_7",    16'd1000,  16'd7,     1'b0, 0);
      run_op("s_m7_2",     16'hFFF9,  16'h0002,  1'b1, 0);
      run_op("s_7_m2",     16'h0007,  16'hFFFE,  1'b1, 0);
      run_op("dbz",        16'h1234,  16'h0000,  1'b0, 0);
      run_op("zero_dvd",   16'h0000,  16'd5,     1'b0, 0);
      run_op("dbz_signed", 16'h8001,  16'h0000,  1'b1, 0);
      run_op("s_ovf",      16'h8000,  16'hFFFF,  1'b1, 0);
      run_op("u_ffff_1",   16'hFFFF,  16'h0001,  1'b0, 0);
      run_op("u_ffff_big", 16'hFFFF,  16'hFFFF,  1'b0, 0);
      run_op("backpress",  16'd54321, 16'd123,   1'b0, 10);
      run_op("u100_10",    16'd100,   16'd10,    1'b0, 0);

      // Reset in the middle of the iteration phase.
      bus.dividend  = 16'd60000;
      bus.divisor   = 16'd3;
      bus.signed_op = 1'b0;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (6) tick();
      check("midrst_busy_before", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_state("midrst");
      tick();
      rst_n = 1'b1;
      tick();
      check("midrst_ready_after", bus.in_ready, 1);
      run_op("u60000_3", 16'd60000, 16'd3, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         sel = int'($urandom_range(0, 9));
         if (sel == 0) rb = 16'h0;
         else if (sel == 1) ra = 16'h0;
         else if (sel <= 4) rb = 16'($urandom_range(1, 300));
         else if (sel == 5) rb = -16'($urandom_range(1, 300));
         run_op("rand", ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
